vram_access_scheduler: RTL and testbench

- Sits between the V9958 core's VRAM port and the 16-bit SDRAM memory controller, on the pixel clock domain.
- Detects VDP access and idle windows from the DHClk/DLClk phase pair and turns each access window into exactly one read or write command.
- Inserts refresh commands in idle windows, and forces a refresh when the interval limit is reached.
- Presents read data to the VDP and holds it stable until the next read completes.

---
 rtl/vram_access_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_vram_access_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_scheduler.sv
// VRAM access scheduler: converts V9958 access windows into SDRAM read/write
// commands, slips refreshes into idle windows and forces one at the interval limit.
module vram_access_scheduler #(
    parameter int unsigned REFRESH_MIN  = 256,
    parameter int unsigned REFRESH_MAX  = 800,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned ADDR_W       = 21
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vdp_dlclk,
    input  logic              vdp_dhclk,
    input  logic              vdp_we_n,
    input  logic [16:0]       vdp_adr,
    input  logic [7:0]        vdp_dbo,
    output logic [15:0]       vdp_dbi,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_wdm,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy,
    input  logic              status_clr,
    output logic              overrun,
    output logic              timeout
);

    localparam int unsigned CntW = $clog2(REFRESH_MAX + 1);
    localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] RefMin  = CntW'(REFRESH_MIN);
    localparam logic [CntW-1:0] RefMax  = CntW'(REFRESH_MAX);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              rd_cmd_q, rd_cmd_d;
    logic              acc_q, acc_prev_q, idle_q, idle_prev_q;
    logic              slot_ev, idle_ev;
    logic              pend_q, pend_we_q;
    logic [15:0]       pend_addr_q, pend_din_q;
    logic [1:0]        pend_wdm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q, dbi_q;
    logic [1:0]        wdm_q;
    logic [CntW-1:0]   ref_cnt_q;
    logic              idle_seen_q, ref_due;
    logic              issue_acc, issue_ref;
    logic              timeout_set, dbi_load, overrun_set;
    logic              overrun_q, timeout_q;

    assign slot_ev = acc_q & ~acc_prev_q;
    assign idle_ev = idle_q & ~idle_prev_q;
    assign ref_due = (idle_seen_q && (ref_cnt_q >= RefMin)) || (ref_cnt_q >= RefMax);

    // Pending access always beats refresh; nothing is issued while the controller is busy.
    assign issue_acc   = (state_q == StIdle) && pend_q && !mem_busy;
    assign issue_ref   = (state_q == StIdle) && !pend_q && ref_due && !mem_busy;
    // Losing an access only counts when the older one is not leaving this cycle.
    assign overrun_set = slot_ev && pend_q && !issue_acc;

    assign mem_read    = issue_acc & ~pend_we_q;
    assign mem_write   = issue_acc & pend_we_q;
    assign mem_refresh = issue_ref;
    assign mem_addr    = issue_acc ? ADDR_W'(pend_addr_q) : addr_q;
    assign mem_din     = issue_acc ? pend_din_q : din_q;
    assign mem_wdm     = issue_acc ? pend_wdm_q : wdm_q;
    assign vdp_dbi     = dbi_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

    // Register the phase windows and their previous values for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= 1'b0;
            acc_prev_q  <= 1'b0;
            idle_q      <= 1'b0;
            idle_prev_q <= 1'b0;
        end else begin
            acc_q       <= vdp_dlclk & vdp_dhclk;
            acc_prev_q  <= acc_q;
            idle_q      <= ~vdp_dlclk & ~vdp_dhclk;
            idle_prev_q <= idle_q;
        end
    end

    // Slot capture; a newer slot simply overwrites an older pending access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            pend_wdm_q  <= '0;
        end else if (slot_ev) begin
            pend_q      <= 1'b1;
            pend_we_q   <= ~vdp_we_n;
            pend_addr_q <= vdp_adr[15:0];
            pend_din_q  <= {vdp_dbo, vdp_dbo};
            pend_wdm_q  <= {~vdp_adr[16], vdp_adr[16]};
        end else if (issue_acc) begin
            pend_q      <= 1'b0;
        end
    end

    // Hold the last command's address/data/mask between commands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            din_q  <= '0;
            wdm_q  <= '0;
        end else if (issue_acc) begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
            wdm_q  <= mem_wdm;
        end
    end

    // Refresh interval counter and idle-window tracking since the last command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt_q   <= '0;
            idle_seen_q <= 1'b0;
        end else begin
            if (issue_ref) begin
                ref_cnt_q <= '0;
            end else if (ref_cnt_q < RefMax) begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
            end
            if (idle_ev) begin
                idle_seen_q <= 1'b1;
            end else if (issue_acc || issue_ref) begin
                idle_seen_q <= 1'b0;
            end
        end
    end

    // Command FSM next-state logic.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        rd_cmd_d    = rd_cmd_q;
        timeout_set = 1'b0;
        dbi_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue_acc) begin
                    state_d  = StWaitAck;
                    tmr_d    = '0;
                    rd_cmd_d = ~pend_we_q;
                end else if (issue_ref) begin
                    state_d  = StWaitAck;
                    tmr_d    = '0;
                    rd_cmd_d = 1'b0;
                end
            end
            StWaitAck: begin
                if (mem_busy) begin
                    state_d = StWaitDone;
                end else if (tmr_q == TmrLast) begin
                    timeout_set = 1'b1;
                    state_d     = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StWaitDone: begin
                // Busy was high on entry, so the first low cycle is the falling edge.
                if (!mem_busy) begin
                    dbi_load = rd_cmd_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, read-data holding register and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            rd_cmd_q  <= 1'b0;
            dbi_q     <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            rd_cmd_q <= rd_cmd_d;
            if (dbi_load) begin
                dbi_q <= mem_dout;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (status_clr) begin
                overrun_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (status_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Scoreboard bench for vram_access_scheduler: expected commands are queued when a
// slot is driven and compared when the DUT pulses mem_read/mem_write.
module tb_vram_access_scheduler;

    typedef struct packed {
        logic        we;
        logic [20:0] addr;
        logic [15:0] din;
        logic [1:0]  wdm;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        vdp_dlclk = 1'b0, vdp_dhclk = 1'b0, vdp_we_n = 1'b1;
    logic [16:0] vdp_adr = '0;
    logic [7:0]  vdp_dbo = '0;
    logic [15:0] vdp_dbi;
    logic        mem_read, mem_write, mem_refresh;
    logic [20:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_wdm;
    logic [15:0] mem_dout = '0;
    logic        mem_busy = 1'b0;
    logic        status_clr = 1'b0;
    logic        overrun, timeout;

    int   tests = 0, failures = 0;
    cmd_t exp_q[$];
    int   cyc = 0, last_ref = 0, ref_gap = 0, n_cmd = 0;
    bit   cmd_seen = 0, resp_en = 0;
    int   resp_cnt = 0;
    logic [15:0] resp_data = '0;

    vram_access_scheduler dut (
        .clk(clk), .reset_n(reset_n), .vdp_dlclk(vdp_dlclk), .vdp_dhclk(vdp_dhclk),
        .vdp_we_n(vdp_we_n), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_dbi(vdp_dbi),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm), .mem_dout(mem_dout),
        .mem_busy(mem_busy), .status_clr(status_clr), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Monitor: scoreboard compare on access pulses, pulse invariants, refresh spacing.
    always @(negedge clk) begin
        cmd_t e;
        cyc++;
        cmd_seen = mem_read | mem_write | mem_refresh;
        if (cmd_seen) n_cmd++;
        if ($countones({mem_read, mem_write, mem_refresh}) > 1) begin
            tests++; failures++;
            $display("FAIL onehot: pulses r/w/f=%b%b%b, required at most one", mem_read, mem_write, mem_refresh);
        end
        if (cmd_seen && mem_busy) begin
            tests++; failures++;
            $display("FAIL cmd_while_busy: command pulse with mem_busy=1, required none");
        end
        if (mem_refresh) begin
            ref_gap  = cyc - last_ref;
            last_ref = cyc;
        end
        if (mem_read || mem_write) begin
            tests++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: we=%b addr=%h, required no access", mem_write, mem_addr);
            end else begin
                e = exp_q.pop_front();
                if ({mem_write, mem_addr, mem_din, mem_wdm} !== {e.we, e.addr, e.din, e.wdm}) begin
                    failures++;
                    $display("FAIL sb_cmd: got we=%b addr=%h din=%h wdm=%b, required we=%b addr=%h din=%h wdm=%b",
                             mem_write, mem_addr, mem_din, mem_wdm, e.we, e.addr, e.din, e.wdm);
                end
            end
        end
    end

    // Controller model: busy for 3 cycles after a command, then returns resp_data.
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_busy = 1'b0;
                    mem_dout = resp_data;
                end
            end else if (cmd_seen) begin
                mem_busy = 1'b1;
                resp_cnt = 3;
            end
        end
    end

    task automatic neutral();
        vdp_dlclk = 1'b1;
        vdp_dhclk = 1'b0;
    endtask

    task automatic slot(input logic [16:0] adr, input logic [7:0] dbo, input logic we_n,
                        input bit expect_it);
        cmd_t e;
        e.we   = ~we_n;
        e.addr = {5'b0, adr[15:0]};
        e.din  = {dbo, dbo};
        e.wdm  = {~adr[16], adr[16]};
        if (expect_it) exp_q.push_back(e);
        @(posedge clk); #1;
        vdp_adr = adr; vdp_dbo = dbo; vdp_we_n = we_n;
        vdp_dlclk = 1'b1; vdp_dhclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 neutral();
    endtask

    task automatic wait_drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_busy && resp_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests += 9;
        if (mem_read !== 1'b0)    begin failures++; $display("FAIL rst_read: %b vs 0", mem_read); end
        if (mem_write !== 1'b0)   begin failures++; $display("FAIL rst_write: %b vs 0", mem_write); end
        if (mem_refresh !== 1'b0) begin failures++; $display("FAIL rst_refresh: %b vs 0", mem_refresh); end
        if (mem_addr !== 21'h0)   begin failures++; $display("FAIL rst_addr: %h vs 0", mem_addr); end
        if (mem_din !== 16'h0)    begin failures++; $display("FAIL rst_din: %h vs 0", mem_din); end
        if (mem_wdm !== 2'b00)    begin failures++; $display("FAIL rst_wdm: %b vs 0", mem_wdm); end
        if (vdp_dbi !== 16'h0)    begin failures++; $display("FAIL rst_dbi: %h vs 0", vdp_dbi); end
        if (overrun !== 1'b0)     begin failures++; $display("FAIL rst_overrun: %b vs 0", overrun); end
        if (timeout !== 1'b0)     begin failures++; $display("FAIL rst_timeout: %b vs 0", timeout); end
    endtask

    task automatic test_idle_refresh();
        int n;
        bit found;
        bit ok;
        resp_en = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        found = 1'b0; n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mem_refresh) begin found = 1'b1; n = i; break; end
        end
        tests++;
        if (!found || n < 256 || n > 260) begin
            failures++;
            $display("FAIL idle_refresh: found=%0d at cycle %0d, required within 256..260", found, n);
        end
        neutral();
        wait_drain(20, ok);
    endtask

    task automatic test_write();
        bit found, ok;
        slot(17'h1_2345, 8'hA5, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin failures++; $display("FAIL write_pulse: no mem_write, required one"); end
        if (found) begin
            tests += 3;
            if (mem_addr !== 21'h02345) begin failures++; $display("FAIL write_addr: %h vs 02345", mem_addr); end
            if (mem_din !== 16'hA5A5)   begin failures++; $display("FAIL write_din: %h vs a5a5", mem_din); end
            if (mem_wdm !== 2'b01)      begin failures++; $display("FAIL write_wdm: %b vs 01", mem_wdm); end
            @(negedge clk);
            tests++;
            if (mem_write !== 1'b0) begin failures++; $display("FAIL write_width: %b vs 0", mem_write); end
        end
        wait_drain(30, ok);
        tests++;
        if (!ok) begin failures++; $display("FAIL write_drain: queue %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_read();
        bit ok;
        resp_data = 16'hBEEF;
        slot(17'h0_0010, 8'h5A, 1'b1, 1'b1);
        wait_drain(30, ok);
        tests += 2;
        if (!ok) begin failures++; $display("FAIL read_drain: queue %0d, required 0", exp_q.size()); end
        if (vdp_dbi !== 16'hBEEF) begin failures++; $display("FAIL read_dbi: %h vs beef", vdp_dbi); end
        resp_data = 16'h1111;
        slot(17'h1_0020, 8'h66, 1'b0, 1'b1);
        wait_drain(30, ok);
        tests += 2;
        if (!ok) begin failures++; $display("FAIL read_wr_drain: queue %0d, required 0", exp_q.size()); end
        if (vdp_dbi !== 16'hBEEF) begin failures++; $display("FAIL read_hold: %h vs beef", vdp_dbi); end
    endtask

    task automatic test_overrun();
        bit ok;
        @(posedge clk); #1 resp_en = 1'b0; mem_busy = 1'b1;
        slot(17'h0_0100, 8'h01, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        slot(17'h0_0200, 8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: %b vs 1", overrun); end
        @(posedge clk); #1 mem_busy = 1'b0; resp_en = 1'b1;
        wait_drain(30, ok);
        tests += 2;
        if (!ok) begin failures++; $display("FAIL overrun_drain: queue %0d, required 0", exp_q.size()); end
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: %b vs 1", overrun); end
        @(posedge clk); #1 status_clr = 1'b1;
        @(posedge clk); #1 status_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr: %b vs 0", overrun); end
    endtask

    task automatic test_timeout();
        bit found, ok;
        @(posedge clk); #1 resp_en = 1'b0; mem_busy = 1'b0;
        slot(17'h0_0030, 8'h00, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin failures++; $display("FAIL timeout_read: no mem_read, required one"); end
        repeat (8) @(negedge clk);
        tests++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_early: %b vs 0", timeout); end
        repeat (12) @(negedge clk);
        tests += 2;
        if (timeout !== 1'b1)     begin failures++; $display("FAIL timeout_set: %b vs 1", timeout); end
        if (vdp_dbi !== 16'hBEEF) begin failures++; $display("FAIL timeout_dbi: %h vs beef", vdp_dbi); end
        resp_en = 1'b1;
        slot(17'h0_0040, 8'h77, 1'b0, 1'b1);
        wait_drain(30, ok);
        tests++;
        if (!ok) begin failures++; $display("FAIL timeout_next: queue %0d, required 0", exp_q.size()); end
        @(posedge clk); #1 status_clr = 1'b1;
        @(posedge clk); #1 status_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clr: %b vs 0", timeout); end
    endtask

    task automatic test_forced_refresh();
        bit found, ok;
        cmd_t e;
        e.we = 1'b1; e.addr = 21'h00070; e.din = 16'h1111; e.wdm = 2'b10;
        exp_q.push_back(e);
        @(posedge clk); #1;
        vdp_adr = 17'h0_0070; vdp_dbo = 8'h11; vdp_we_n = 1'b0;
        vdp_dlclk = 1'b1; vdp_dhclk = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (mem_refresh) begin found = 1'b1; break; end
        end
        #1;
        tests += 2;
        if (!found) begin failures++; $display("FAIL forced_found: no refresh, required one"); end
        if (ref_gap < 800 || ref_gap > 804) begin
            failures++; $display("FAIL forced_gap: %0d cycles, required 800..804", ref_gap);
        end
        neutral();
        wait_drain(20, ok);
        tests++;
        if (!ok) begin failures++; $display("FAIL forced_drain: queue %0d, required 0", exp_q.size()); end
        // Saturate the counter while busy, then check the pending access goes first.
        @(posedge clk); #1 resp_en = 1'b0; mem_busy = 1'b1;
        repeat (820) @(posedge clk);
        slot(17'h1_0050, 8'hC3, 1'b0, 1'b1);
        @(posedge clk); #1 mem_busy = 1'b0; resp_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_read || mem_write || mem_refresh) begin found = 1'b1; break; end
        end
        tests++;
        if (!found || mem_write !== 1'b1 || mem_refresh !== 1'b0) begin
            failures++;
            $display("FAIL prio_first: found=%0d w=%b f=%b, required write first", found, mem_write, mem_refresh);
        end
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_refresh) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin failures++; $display("FAIL prio_refresh: no refresh after access, required one"); end
        wait_drain(20, ok);
    endtask

    task automatic test_reset_mid();
        bit found;
        int n0;
        resp_data = 16'h4242;
        slot(17'h0_0060, 8'h00, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin failures++; $display("FAIL mid_read: no mem_read, required one"); end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests += 4;
        if (vdp_dbi !== 16'h0) begin failures++; $display("FAIL mid_dbi: %h vs 0", vdp_dbi); end
        if (mem_addr !== 21'h0) begin failures++; $display("FAIL mid_addr: %h vs 0", mem_addr); end
        if (mem_din !== 16'h0) begin failures++; $display("FAIL mid_din: %h vs 0", mem_din); end
        if ({mem_read, mem_write, mem_refresh} !== 3'b000) begin
            failures++; $display("FAIL mid_pulses: %b vs 000", {mem_read, mem_write, mem_refresh});
        end
        resp_en = 1'b0; mem_busy = 1'b0; resp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        n0 = n_cmd;
        repeat (60) @(negedge clk);
        tests += 3;
        if (n_cmd != n0) begin failures++; $display("FAIL mid_quiet: %0d pulses, required 0", n_cmd - n0); end
        if (vdp_dbi !== 16'h0) begin failures++; $display("FAIL mid_dbi_after: %h vs 0", vdp_dbi); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL mid_queue: %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_write();
        test_read();
        test_overrun();
        test_timeout();
        test_forced_refresh();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
